// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the loadable up-counter and down-timer blocks.
//   Holds the timer state encoding, its enumerated type and the default
//   counter/data width.
// -----------------------------------------------------------------------------
package counter_pkg;

   // Timer state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;   // no valid start value loaded
   localparam logic [1:0] ST_RUN  = 2'd1;   // counting
   localparam logic [1:0] ST_DONE = 2'd2;   // one-shot expired

   // Default counter/data width
   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

endpackage : counter_pkg

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//   Loadable down-counter / timer. A load captures d into both the count and
//   the reload register. Each enabled edge decrements the count; reaching zero
//   raises a one-cycle tc pulse. In one-shot mode the timer then parks in DONE.
//   In periodic mode the zero count is followed by a reload, which gives a
//   period of reload+1 enabled cycles.
//
// Ports
//   clk       in   1  rising-edge clock
//   reset_n   in   1  asynchronous active-low reset
//   d         in   N  start/reload value, sampled when load=1
//   load      in   1  load d into count and reload register (wins over en)
//   en        in   1  count enable
//   periodic  in   1  1 = auto-reload after terminal count, 0 = one-shot
//   q         out  N  current count (registered)
//   tc        out  1  terminal-count pulse, high for one cycle (registered)
//   busy      out  1  high while counting (registered)
// -----------------------------------------------------------------------------
module down_timer
   import counter_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] d,
   input  logic         load,
   input  logic         en,
   input  logic         periodic,
   output logic [N-1:0] q,
   output logic         tc,
   output logic         busy
);

   localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
   localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

   state_t       state_r;
   state_t       state_s;
   logic [N-1:0] q_r;
   logic [N-1:0] q_s;
   logic [N-1:0] reload_r;
   logic [N-1:0] reload_s;
   logic         tc_r;
   logic         tc_s;
   logic         busy_r;
   logic         busy_s;

   // State, count, reload value and output flops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= S_IDLE;
         q_r      <= CNT_ZERO;
         reload_r <= CNT_ZERO;
         tc_r     <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         q_r      <= q_s;
         reload_r <= reload_s;
         tc_r     <= tc_s;
         busy_r   <= busy_s;
      end
   end

   // Next-state, next-count and terminal-count decode; load beats enable
   always_comb begin
      state_s  = state_r;
      q_s      = q_r;
      reload_s = reload_r;
      tc_s     = 1'b0;

      if (load) begin
         reload_s = d;
         q_s      = d;
         // A zero start value can never produce a terminal count
         if (d != CNT_ZERO) begin
            state_s = S_RUN;
         end else begin
            state_s = S_IDLE;
         end
      end else if (en) begin
         case (state_r)
            S_RUN: begin
               if (q_r == CNT_ONE) begin
                  // periodic is sampled only on this edge
                  q_s  = CNT_ZERO;
                  tc_s = 1'b1;
                  if (periodic) begin
                     state_s = S_RUN;
                  end else begin
                     state_s = S_DONE;
                  end
               end else if (q_r == CNT_ZERO) begin
                  // Only reachable after a periodic terminal count
                  q_s = reload_r;
               end else begin
                  q_s = q_r - CNT_ONE;
               end
            end
            S_IDLE: begin
               q_s = q_r;
            end
            S_DONE: begin
               q_s = q_r;
            end
            default: begin
               // Unreachable encoding: recover to a safe idle state
               state_s = S_IDLE;
               q_s     = CNT_ZERO;
            end
         endcase
      end else begin
         q_s = q_r;
      end

      busy_s = (state_s == S_RUN);
   end

   assign q    = q_r;
   assign tc   = tc_r;
   assign busy = busy_r;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
//   Self-checking bench for down_timer (N=4). Directed scenarios followed by
//   randomized load/en/periodic/reset traffic, all compared every cycle
//   against a behavioural model that tracks only "count", "reload value" and
//   "still counting".
// -----------------------------------------------------------------------------
module tb_down_timer;

   logic       clk;
   logic       reset_n;
   logic [3:0] d;
   logic       load;
   logic       en;
   logic       periodic;
   logic [3:0] q;
   logic       tc;
   logic       busy;

   int n_cmp;
   int n_err;

   // Behavioural model
   int m_q;
   int m_reload;
   bit m_tc;
   bit m_counting;

   down_timer #(.N(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .d        (d),
      .load     (load),
      .en       (en),
      .periodic (periodic),
      .q        (q),
      .tc       (tc),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q        = 0;
      m_reload   = 0;
      m_tc       = 1'b0;
      m_counting = 1'b0;
   endtask

   // One rising edge of the timer as described in words: load wins, then
   // an enabled edge either counts down, or after hitting zero reloads.
   task automatic model_edge();
      if (load) begin
         m_reload   = int'(d);
         m_q        = int'(d);
         m_tc       = 1'b0;
         m_counting = (d != 4'd0);
      end else if (en && m_counting) begin
         if (m_q == 0) begin
            m_q  = m_reload;
            m_tc = 1'b0;
         end else begin
            m_q  = m_q - 1;
            m_tc = (m_q == 0);
            if (m_q == 0 && !periodic) m_counting = 1'b0;
         end
      end else begin
         m_tc = 1'b0;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".q"},    32'(q),    32'(m_q));
      chk({tag, ".tc"},   32'(tc),   32'(m_tc));
      chk({tag, ".busy"}, 32'(busy), 32'(m_counting));
   endtask

   // Apply inputs (already set), clock one edge, compare on the falling edge
   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic drive(input logic [3:0] dv, input logic ld, input logic e, input logic p);
      d        = dv;
      load     = ld;
      en       = e;
      periodic = p;
   endtask

   // Asynchronous reset pulse between edges, checked before the next edge
   task automatic async_reset(input string tag);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk({tag, ".rst_q"},    32'(q),    32'd0);
      chk({tag, ".rst_tc"},   32'(tc),   32'd0);
      chk({tag, ".rst_busy"}, 32'(busy), 32'd0);
      #1;
      reset_n = 1'b1;
   endtask

   int tc_cnt;
   int first_tc;
   int second_tc;

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      drive(4'd0, 1'b0, 1'b0, 1'b0);
      model_reset();
      #3;
      chk("por.q",    32'(q),    32'd0);
      chk("por.tc",   32'(tc),   32'd0);
      chk("por.busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset mid-count at q=6
      drive(4'd8, 1'b1, 1'b0, 1'b0); cycle("rst_ld");
      drive(4'd0, 1'b0, 1'b1, 1'b0); cycle("rst_cnt"); cycle("rst_cnt");
      chk("rst.pre_q", 32'(q), 32'd6);
      async_reset("midcount");
      @(negedge clk);
      check_model("rst_after");

      // One-shot from 10
      drive(4'd10, 1'b1, 1'b0, 1'b0); cycle("os_ld");
      chk("os.ld_q", 32'(q), 32'd10);
      drive(4'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 9; i >= 0; i--) begin
         cycle("os_run");
         chk("os.seq", 32'(q), 32'(i));
         chk("os.tc",  32'(tc), (i == 0) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 5; i++) begin
         cycle("os_hold");
         chk("os.hold_q",    32'(q),    32'd0);
         chk("os.hold_busy", 32'(busy), 32'd0);
      end

      // Periodic with reload 3
      drive(4'd3, 1'b1, 1'b0, 1'b1); cycle("per_ld");
      drive(4'd0, 1'b0, 1'b1, 1'b1);
      tc_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         cycle("per_run");
         if (tc) tc_cnt++;
      end
      chk("per.pulses", 32'(tc_cnt), 32'd3);

      // Enable gaps from 4, one-shot
      drive(4'd4, 1'b1, 1'b0, 1'b0); cycle("gap_ld");
      tc_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         drive(4'd0, 1'b0, (i % 2 == 0), 1'b0);
         cycle("gap_run");
         if (tc) tc_cnt++;
      end
      chk("gap.pulses", 32'(tc_cnt), 32'd1);

      // Simultaneous load and enable
      drive(4'd2, 1'b1, 1'b0, 1'b0); cycle("sim_pre");
      drive(4'd5, 1'b1, 1'b1, 1'b0); cycle("sim_ld");
      chk("sim.q",  32'(q),  32'd5);
      chk("sim.tc", 32'(tc), 32'd0);

      // Load zero
      drive(4'd0, 1'b1, 1'b0, 1'b0); cycle("zero_ld");
      drive(4'd0, 1'b0, 1'b1, 1'b1);
      tc_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cycle("zero_run");
         if (tc) tc_cnt++;
      end
      chk("zero.pulses", 32'(tc_cnt), 32'd0);
      chk("zero.busy",   32'(busy),   32'd0);

      // Full range periodic from 15: period of 16 enabled cycles
      drive(4'd15, 1'b1, 1'b0, 1'b1); cycle("full_ld");
      drive(4'd0, 1'b0, 1'b1, 1'b1);
      tc_cnt    = 0;
      first_tc  = -1;
      second_tc = -1;
      for (int i = 1; i <= 40; i++) begin
         cycle("full_run");
         if (tc) begin
            tc_cnt++;
            if (first_tc < 0) first_tc = i;
            else if (second_tc < 0) second_tc = i;
         end
      end
      chk("full.pulses", 32'(tc_cnt),               32'd2);
      chk("full.first",  32'(first_tc),             32'd15);
      chk("full.period", 32'(second_tc - first_tc), 32'd16);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive(4'($urandom_range(0, 15)),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 19) == 0) ? ~periodic : periodic);
         cycle("rnd");
         if ($urandom_range(0, 99) == 0) begin
            async_reset("rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_down_timer
